pixel_cache: RTL and testbench
==============================

# pixel_cache

- Responder end of the pixel-request interface used by the edge-search blocks.
- Accepts a pixel coordinate, returns the one-bit binarized pixel with a `ready` pulse.
- Backed by a direct-mapped cache of 16-pixel words, refilled from the binarized frame memory over a variable-latency read port.
- Sits between the edge searchers and the frame buffer, so repeated scans of a small search window rarely touch memory.

## Interface

- `FRAME_W`, 640: frame width in pixels; multiple of 16.
- `FRAME_H`, 480: frame height in pixels.
- `ENTRIES`, 8: cache entries (16-pixel words); power of two, 2..64.
- `HOLDOFF`, 2: dead cycles after each `ready` pulse before `request` is sampled again; 0..7.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous and active-low.
- `x` in 10: requested pixel column.
- `y` in 10: requested pixel row.
- `request` in 1: level; high means (`x`,`y`) is a valid request.
- `pixel` out 1: pixel value, valid only while `ready` is high.
- `ready` out 1: one-cycle response pulse.
- `flush` in 1: one-cycle pulse; invalidates all entries (new frame written).
- `mem_addr` out 15: word address, computed as `y*(FRAME_W/16) + x[9:4]`.
- `mem_rd` out 1: read request; held with `mem_addr` stable until `mem_valid`.
- `mem_rdata` in 16: read word; bit 0 is the leftmost pixel.
- `mem_valid` in 1: `mem_rdata` valid this cycle.
- `hit_count` out 16: present only with `PIXEL_CACHE_STATS_EN`.
- `miss_count` out 16: present only with `PIXEL_CACHE_STATS_EN`.

## Operation

- Word address: WA = `y*(FRAME_W/16) + x[9:4]`.
  - Index = WA[log2(ENTRIES)-1:0].
  - Tag = remaining upper bits of WA.
  - Each entry holds a valid bit, a tag and a 16-bit word.
- FSM states: IDLE, LOOKUP, FETCH, RESPOND, HOLDOFF.
  - **IDLE:** if `request`=1, register `x`, `y` and WA, then go to LOOKUP.
  - **LOOKUP:**
    - Out of frame (`x`>=FRAME_W or `y`>=FRAME_H): go to RESPOND with pixel 0 and no memory access.
    - Hit (valid and tag match, no `flush` this cycle): go to RESPOND.
    - Otherwise: go to FETCH.
  - **FETCH:** `mem_rd`=1 and `mem_addr`=WA. On `mem_valid`, latch `mem_rdata`, install it at the index (tag set, valid=1), then go to RESPOND.
  - **RESPOND:** `ready`=1, `pixel` = word[`x`[3:0]]. Go to HOLDOFF if HOLDOFF>0, else IDLE.
  - **HOLDOFF:** count HOLDOFF cycles with `request` ignored, then go to IDLE.
- Holdoff rationale: the initiator keeps `request` high across lookups and presents its next coordinate two cycles after `ready`. The default HOLDOFF=2 prevents resampling a stale coordinate.
- `flush`:
  - Clears all valid bits on the following edge, in any state.
  - A LOOKUP in the same cycle as `flush` is a miss.
  - `flush` asserted during FETCH (including the `mem_valid` cycle): the fetched word is still returned on `pixel` but is not installed.
- Miss replacement: an existing entry at the index is overwritten; no write-back is needed (read-only).
- WA arithmetic is 15-bit unsigned and is never computed for out-of-frame coordinates.

## Timing

- Reset values: `ready` 0, `pixel` 0, `mem_rd` 0, `mem_addr` 0, all valid bits 0, state IDLE, counters 0.
- Hit: `request` sampled in IDLE at cycle N → LOOKUP at N+1 → `ready` at N+2.
- Out-of-frame: same latency as a hit.
- Miss:
  - `mem_rd` rises at N+2.
  - If `mem_valid` arrives at cycle M, `mem_rd` is low from M+1 and `ready` is high at M+1.
  - Minimum miss latency is 3 cycles, with `mem_valid` at N+2.
- `mem_rdata` is ignored outside FETCH. `mem_valid` outside FETCH is ignored.
- Back-to-back throughput with hits: one response every 3+HOLDOFF cycles.
- Reset asserted mid-FETCH: `mem_rd` drops asynchronously and the cache comes up empty. A late `mem_valid` after release is ignored.

## Configuration

- `PIXEL_CACHE_STATS_EN` defined:
  - `hit_count` increments per LOOKUP hit; `miss_count` increments per FETCH entry.
  - Both are 16-bit saturating counters, cleared by reset (not by `flush`).
  - Out-of-frame lookups count as neither.
- `PIXEL_CACHE_STATS_EN` undefined: the ports and counters do not exist.

## Test plan

- Miss fill: after reset, request (5,3).
  - `mem_rd`=1 with `mem_addr`=120.
  - Memory returns 16'h0020 with `mem_valid` 4 cycles later.
  - Next cycle: `ready`=1, `pixel`=1.
- Hit: after holdoff, request (4,3) → no `mem_rd`, `ready` two cycles after sampling, `pixel`=0.
  - With `PIXEL_CACHE_STATS_EN`: `hit_count`=1, `miss_count`=1.
- Conflict eviction (ENTRIES=8): request (128,3), WA=128, same index as 120 → miss, fill 16'h0001, `pixel`=1. Then request (5,3) → misses again, `mem_addr`=120.
- Out of frame: request (700,10) → `ready` at N+2 with `pixel`=0; `mem_rd` never asserted.
- Flush during FETCH: pulse `flush` while waiting on request (5,3).
  - Response `pixel`=1 still returned.
  - Next request (5,3) misses again.
- Reset mid-FETCH: drop `reset` while `mem_rd`=1.
  - `mem_rd` and `ready` go to 0 immediately.
  - After release, a stray `mem_valid` produces no `ready`.
  - The next request misses.

Source files
------------

// File: rtl/pixel_cache_if.sv
// Pixel-request and frame-memory read signals of pixel_cache.
// slave = the cache; master = edge searcher plus frame memory.
interface pixel_cache_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        request;
   logic        flush;
   logic        pixel;
   logic        ready;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_valid;

   modport slave (
      input  x, y, request, flush, mem_rdata, mem_valid,
      output pixel, ready, mem_addr, mem_rd
   );

   modport master (
      output x, y, request, flush, mem_rdata, mem_valid,
      input  pixel, ready, mem_addr, mem_rd
   );
endinterface

// File: rtl/pixel_cache.sv
// Direct-mapped cache of 16-pixel binarized words answering single-pixel requests.
// Optional hit/miss statistics ports are enabled with PIXEL_CACHE_STATS_EN.
module pixel_cache #(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int ENTRIES = 8,
   parameter int HOLDOFF = 2
) (
   input  logic          clk,
   input  logic          reset,
   pixel_cache_if.slave  bus
`ifdef PIXEL_CACHE_STATS_EN
   ,
   output logic [15:0]   hit_count,
   output logic [15:0]   miss_count
`endif
);

   localparam int          IDX_W   = $clog2(ENTRIES);
   localparam int          TAG_W   = 15 - IDX_W;
   localparam logic [14:0] WPR     = 15'(FRAME_W / 16);
   localparam logic [10:0] FW      = 11'(FRAME_W);
   localparam logic [10:0] FH      = 11'(FRAME_H);
   localparam logic [2:0]  HO_LAST = 3'(HOLDOFF - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_FETCH, S_RESPOND, S_HOLDOFF
   } state_t;

   state_t                  state_q;
   logic [3:0]              x_lo_q;
   logic [14:0]             wa_q;
   logic                    oof_q;
   logic                    fetch_flushed_q;
   logic [2:0]              hold_cnt_q;
   logic                    ready_q;
   logic                    pixel_q;
   logic                    mem_rd_q;
   logic [14:0]             mem_addr_q;

   logic [ENTRIES-1:0]      valid_q;
   logic [TAG_W-1:0]        tag_q  [ENTRIES];
   logic [15:0]             data_q [ENTRIES];

   logic                    in_frame_s;
   logic [14:0]             wa_d;
   logic [IDX_W-1:0]        idx_s;
   logic [TAG_W-1:0]        tag_s;
   logic                    hit_s;
   logic                    install_s;

   // Address decode of the incoming coordinate and lookup/install decisions.
   always_comb begin
      in_frame_s = ({1'b0, bus.x} < FW) && ({1'b0, bus.y} < FH);
      if (in_frame_s) begin
         wa_d = ({5'd0, bus.y} * WPR) + {9'd0, bus.x[9:4]};
      end else begin
         wa_d = 15'd0;
      end
      idx_s     = wa_q[IDX_W-1:0];
      tag_s     = wa_q[14:IDX_W];
      hit_s     = valid_q[idx_s] && (tag_q[idx_s] == tag_s) && !bus.flush;
      install_s = (state_q == S_FETCH) && bus.mem_valid && !bus.flush && !fetch_flushed_q;
   end

   // Request sequencing FSM with registered response and memory outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         x_lo_q          <= 4'd0;
         wa_q            <= 15'd0;
         oof_q           <= 1'b0;
         fetch_flushed_q <= 1'b0;
         hold_cnt_q      <= 3'd0;
         ready_q         <= 1'b0;
         pixel_q         <= 1'b0;
         mem_rd_q        <= 1'b0;
         mem_addr_q      <= 15'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.request) begin
                  x_lo_q  <= bus.x[3:0];
                  wa_q    <= wa_d;
                  oof_q   <= !in_frame_s;
                  state_q <= S_LOOKUP;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_LOOKUP: begin
               if (oof_q) begin
                  ready_q <= 1'b1;
                  pixel_q <= 1'b0;
                  state_q <= S_RESPOND;
               end else if (hit_s) begin
                  ready_q <= 1'b1;
                  pixel_q <= data_q[idx_s][x_lo_q];
                  state_q <= S_RESPOND;
               end else begin
                  mem_rd_q        <= 1'b1;
                  mem_addr_q      <= wa_q;
                  fetch_flushed_q <= 1'b0;
                  state_q         <= S_FETCH;
               end
            end
            S_FETCH: begin
               // A flush while waiting makes the incoming word stale for the cache only.
               if (bus.flush) begin
                  fetch_flushed_q <= 1'b1;
               end else begin
                  fetch_flushed_q <= fetch_flushed_q;
               end
               if (bus.mem_valid) begin
                  mem_rd_q <= 1'b0;
                  ready_q  <= 1'b1;
                  pixel_q  <= bus.mem_rdata[x_lo_q];
                  state_q  <= S_RESPOND;
               end else begin
                  state_q  <= S_FETCH;
               end
            end
            S_RESPOND: begin
               ready_q <= 1'b0;
               pixel_q <= 1'b0;
               if (HOLDOFF > 0) begin
                  hold_cnt_q <= HO_LAST;
                  state_q    <= S_HOLDOFF;
               end else begin
                  state_q    <= S_IDLE;
               end
            end
            S_HOLDOFF: begin
               if (hold_cnt_q == 3'd0) begin
                  state_q <= S_IDLE;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 3'd1;
               end
            end
            default: begin
               ready_q  <= 1'b0;
               pixel_q  <= 1'b0;
               mem_rd_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   // Valid bits: flush wins over an install in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
      end else if (install_s) begin
         valid_q[idx_s] <= 1'b1;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (install_s) begin
         tag_q[idx_s]  <= tag_s;
         data_q[idx_s] <= bus.mem_rdata;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.pixel    = pixel_q;
   assign bus.mem_rd   = mem_rd_q;
   assign bus.mem_addr = mem_addr_q;

`ifdef PIXEL_CACHE_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   // Saturating lookup statistics; out-of-frame lookups are not counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else if ((state_q == S_LOOKUP) && !oof_q) begin
         if (hit_s) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            else hit_cnt_q <= hit_cnt_q;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            else miss_cnt_q <= miss_cnt_q;
         end
      end else begin
         hit_cnt_q  <= hit_cnt_q;
         miss_cnt_q <= miss_cnt_q;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_cache.sv
// Directed self-checking bench for pixel_cache (default parameters).
module tb_pixel_cache;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   pixel_cache_if bus ();

`ifdef PIXEL_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   pixel_cache dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus)
`ifdef PIXEL_CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Present a coordinate for exactly one sampling edge (DUT must be idle).
   task automatic req_at(input logic [9:0] px, input logic [9:0] py);
      bus.x       = px;
      bus.y       = py;
      bus.request = 1'b1;
      tick();
      bus.request = 1'b0;
   endtask

   task automatic respond(input logic [15:0] word);
      bus.mem_rdata = word;
      bus.mem_valid = 1'b1;
      tick();
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'h0000;
   endtask

   // From the ready cycle, walk through RESPOND exit and the holdoff back to idle.
   task automatic settle(input string tag);
      tick();
      check({tag, "_ready_drop"}, {31'd0, bus.ready}, 32'd0);
      tick();
      tick();
   endtask

   task automatic check_stats(input string tag, input logic [15:0] eh, input logic [15:0] em);
`ifdef PIXEL_CACHE_STATS_EN
      check({tag, "_hits"}, {16'd0, hit_count}, {16'd0, eh});
      check({tag, "_misses"}, {16'd0, miss_count}, {16'd0, em});
`else
      if (eh == em) n_checks = n_checks + 0;
`endif
   endtask

   logic [9:0] oof_x [3];
   logic [9:0] oof_y [3];

   initial begin
      n_checks      = 0;
      n_fails       = 0;
      reset         = 1'b0;
      bus.x         = 10'd0;
      bus.y         = 10'd0;
      bus.request   = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.mem_valid = 1'b0;
      oof_x[0] = 10'd700; oof_y[0] = 10'd10;
      oof_x[1] = 10'd640; oof_y[1] = 10'd0;
      oof_x[2] = 10'd0;   oof_y[2] = 10'd480;

      tick();
      tick();
      check("rst_ready", {31'd0, bus.ready}, 32'd0);
      check("rst_pixel", {31'd0, bus.pixel}, 32'd0);
      check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
      check("rst_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
      check_stats("rst", 16'd0, 16'd0);
      reset = 1'b1;
      tick();

      // Miss fill of (5,3): WA = 3*40 + 0 = 120, memory answers 4 cycles later.
      req_at(10'd5, 10'd3);
      check("miss_no_early_rd", {31'd0, bus.mem_rd}, 32'd0);
      tick();
      check("miss_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("miss_mem_addr", {17'd0, bus.mem_addr}, 32'd120);
      tick();
      tick();
      tick();
      check("miss_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("miss_wait_ready", {31'd0, bus.ready}, 32'd0);
      check("miss_wait_addr", {17'd0, bus.mem_addr}, 32'd120);
      respond(16'h0020);
      check("miss_ready", {31'd0, bus.ready}, 32'd1);
      check("miss_pixel", {31'd0, bus.pixel}, 32'd1);
      check("miss_rd_drop", {31'd0, bus.mem_rd}, 32'd0);
      settle("miss");

      // Hit on the same word, bit 4 of 16'h0020 is 0.
      req_at(10'd4, 10'd3);
      check("hit_lookup_ready", {31'd0, bus.ready}, 32'd0);
      tick();
      check("hit_ready", {31'd0, bus.ready}, 32'd1);
      check("hit_pixel", {31'd0, bus.pixel}, 32'd0);
      check("hit_no_rd", {31'd0, bus.mem_rd}, 32'd0);
      check_stats("hit", 16'd1, 16'd1);
      settle("hit");

      // Conflict eviction: WA 128 shares index 0 with WA 120.
      req_at(10'd128, 10'd3);
      tick();
      check("conf_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("conf_addr", {17'd0, bus.mem_addr}, 32'd128);
      respond(16'h0001);
      check("conf_ready", {31'd0, bus.ready}, 32'd1);
      check("conf_pixel", {31'd0, bus.pixel}, 32'd1);
      settle("conf");
      req_at(10'd5, 10'd3);
      tick();
      check("evict_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("evict_addr", {17'd0, bus.mem_addr}, 32'd120);
      respond(16'h0020);
      check("evict_pixel", {31'd0, bus.pixel}, 32'd1);
      settle("evict");
      req_at(10'd5, 10'd3);
      tick();
      check("rehit_ready", {31'd0, bus.ready}, 32'd1);
      check("rehit_pixel", {31'd0, bus.pixel}, 32'd1);
      check("rehit_no_rd", {31'd0, bus.mem_rd}, 32'd0);
      check_stats("conf", 16'd2, 16'd3);
      settle("rehit");

      // Out-of-frame coordinates: hit latency, pixel 0, no memory traffic.
      for (int i = 0; i < 3; i++) begin
         req_at(oof_x[i], oof_y[i]);
         check("oof_lookup_rd", {31'd0, bus.mem_rd}, 32'd0);
         tick();
         check("oof_ready", {31'd0, bus.ready}, 32'd1);
         check("oof_pixel", {31'd0, bus.pixel}, 32'd0);
         check("oof_no_rd", {31'd0, bus.mem_rd}, 32'd0);
         settle("oof");
      end
      check_stats("oof", 16'd2, 16'd3);

      // Last in-frame pixel: WA = 479*40 + 39 = 19199, bit 15 of the word.
      req_at(10'd639, 10'd479);
      tick();
      check("corner_addr", {17'd0, bus.mem_addr}, 32'd19199);
      respond(16'h8000);
      check("corner_pixel", {31'd0, bus.pixel}, 32'd1);
      settle("corner");

      // Flush in the lookup cycle forces a miss; flush during fetch blocks install.
      req_at(10'd5, 10'd3);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flook_rd", {31'd0, bus.mem_rd}, 32'd1);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("ffetch_rd_held", {31'd0, bus.mem_rd}, 32'd1);
      check("ffetch_no_ready", {31'd0, bus.ready}, 32'd0);
      respond(16'h0020);
      check("ffetch_ready", {31'd0, bus.ready}, 32'd1);
      check("ffetch_pixel", {31'd0, bus.pixel}, 32'd1);
      settle("ffetch");
      req_at(10'd5, 10'd3);
      tick();
      check("fmiss_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("fmiss_addr", {17'd0, bus.mem_addr}, 32'd120);
      respond(16'h0020);
      settle("fmiss");
      req_at(10'd5, 10'd3);
      tick();
      check("finst_ready", {31'd0, bus.ready}, 32'd1);
      check("finst_no_rd", {31'd0, bus.mem_rd}, 32'd0);
      check_stats("flush", 16'd3, 16'd6);
      settle("finst");

      // Reset mid-fetch: outputs drop at once, a late mem_valid is ignored.
      req_at(10'd100, 10'd0);
      tick();
      check("rfetch_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("rfetch_addr", {17'd0, bus.mem_addr}, 32'd6);
      #2;
      reset = 1'b0;
      #1;
      check("rasync_rd", {31'd0, bus.mem_rd}, 32'd0);
      check("rasync_ready", {31'd0, bus.ready}, 32'd0);
      check("rasync_addr", {17'd0, bus.mem_addr}, 32'd0);
      tick();
      reset = 1'b1;
      bus.mem_rdata = 16'hFFFF;
      bus.mem_valid = 1'b1;
      tick();
      check("stray_ready_0", {31'd0, bus.ready}, 32'd0);
      tick();
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'h0000;
      check("stray_ready_1", {31'd0, bus.ready}, 32'd0);
      check("stray_rd", {31'd0, bus.mem_rd}, 32'd0);
      check_stats("rreset", 16'd0, 16'd0);
      req_at(10'd5, 10'd3);
      tick();
      check("rmiss_rd", {31'd0, bus.mem_rd}, 32'd1);
      check("rmiss_addr", {17'd0, bus.mem_addr}, 32'd120);
      respond(16'h0020);
      check("rmiss_ready", {31'd0, bus.ready}, 32'd1);
      check("rmiss_pixel", {31'd0, bus.pixel}, 32'd1);
      settle("rmiss");
      check_stats("final", 16'd0, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
